jelly_img_blob_pattern_gen: RTL and testbench

//  Image-stream source: emits jelly img frames (line/pixel first/last, de, data, valid) with one bright

---
 rtl/jelly_img_pkg.sv | 16 +
 rtl/jelly_img_blob_pattern_timing.sv | 99 +++++++++
 rtl/jelly_img_blob_pattern_gen.sv | 153 +++++++++++++++
 tb/tb_jelly_img_blob_pattern_gen.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/jelly_img_pkg.sv
// Shared definitions for the jelly img pattern sources.
//  - state_t   : frame sequencer states (IDLE / ACTIVE / VBLANK)
//  - LFSR_SEED : reset value of the background-noise LFSR
//  - LFSR_TAPS : right-shift Galois mask for x^16+x^14+x^13+x^11+1
package jelly_img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_VBLANK = 2'd2
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/jelly_img_blob_pattern_timing.sv
// Frame sequencer for the blob pattern source.
// Owns the IDLE/ACTIVE/VBLANK FSM and the x/y counters. In VBLANK the same
// counters measure v_blank lines of width+h_blank cycles, so no multiplier.
// Ports:
//  clk, reset_n, cke        clock, async active-low reset, clock enable
//  enable                   run request, looked at only on frame boundaries
//  width/height/h_blank/v_blank  latched frame geometry from the top
//  frame_start              1 on the cke cycle that begins a new frame
//  busy                     state != IDLE
//  active                   current counter position is a valid beat
//  de, pixel_first/last, line_first/last  per-beat flags (0 when !active)
//  x, y                     current counter position
module jelly_img_blob_pattern_timing
  import jelly_img_pkg::*;
#(
  parameter int X_WIDTH = 14,
  parameter int Y_WIDTH = 14
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               cke,
  input  logic               enable,
  input  logic [X_WIDTH-1:0] width,
  input  logic [Y_WIDTH-1:0] height,
  input  logic [X_WIDTH-1:0] h_blank,
  input  logic [Y_WIDTH-1:0] v_blank,
  output logic               frame_start,
  output logic               busy,
  output logic               active,
  output logic               de,
  output logic               pixel_first,
  output logic               pixel_last,
  output logic               line_first,
  output logic               line_last,
  output logic [X_WIDTH-1:0] x,
  output logic [Y_WIDTH-1:0] y
);

  state_t             state, state_next;
  logic [X_WIDTH-1:0] w_eff, x_last;
  logic [Y_WIDTH-1:0] h_eff, y_last;
  logic               x_end, y_end, frame_end;

  // zero-sized frames are promoted to one pixel / one line
  assign w_eff     = (width  == '0) ? X_WIDTH'(1) : width;
  assign h_eff     = (height == '0) ? Y_WIDTH'(1) : height;
  assign x_last    = w_eff + h_blank - X_WIDTH'(1);
  // VBLANK is only entered with v_blank != 0, so v_blank-1 cannot underflow there
  assign y_last    = (state == ST_VBLANK) ? v_blank - Y_WIDTH'(1) : h_eff - Y_WIDTH'(1);
  assign x_end     = (x == x_last);
  assign y_end     = (y == y_last);
  assign frame_end = x_end && y_end;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  state <= ST_IDLE;
    else if (cke)  state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (enable) state_next = ST_ACTIVE;
      ST_ACTIVE: if (frame_end)
                   state_next = (v_blank != '0) ? ST_VBLANK : (enable ? ST_ACTIVE : ST_IDLE);
      ST_VBLANK: if (frame_end) state_next = enable ? ST_ACTIVE : ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    active      = (state == ST_ACTIVE);
    busy        = (state != ST_IDLE);
    // back-to-back frames (v_blank=0) also count as a frame start
    frame_start = cke && (state_next == ST_ACTIVE) && ((state != ST_ACTIVE) || frame_end);
    de          = active && (x < w_eff);
    pixel_first = active && (x == '0);
    pixel_last  = active && x_end;
    line_first  = active && (y == '0);
    line_last   = active && y_end;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      x <= '0;
      y <= '0;
    end else if (cke) begin
      if (frame_start || frame_end || state == ST_IDLE) begin
        x <= '0;
        y <= '0;
      end else if (x_end) begin
        x <= '0;
        y <= y + Y_WIDTH'(1);
      end else begin
        x <= x + X_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/jelly_img_blob_pattern_gen.sv
// Image-stream source: one rectangle of param_fg on a param_bg background.
// Geometry and colours are shadow-latched only at a frame start with
// ctl_update=1; ctl_index counts those applies. Outputs are registered.
// Option: JELLY_IMG_BLOB_PATTERN_GEN_NOISE_EN adds LFSR noise (low 2 bits)
// to background pixels; the LFSR steps on each de beat.
// Ports:
//  clk, reset_n, cke      clock, async active-low reset, clock enable
//  enable, busy           run request / frame (incl. v-blank) in progress
//  ctl_update, ctl_index  apply request / apply counter
//  param_*                next-frame geometry and colours
//  m_img_*                output stream (flags and data qualified by valid/de)
module jelly_img_blob_pattern_gen
  import jelly_img_pkg::*;
#(
  parameter int                    INDEX_WIDTH       = 1,
  parameter int                    DATA_WIDTH        = 8,
  parameter int                    X_WIDTH           = 14,
  parameter int                    Y_WIDTH           = 14,
  parameter int                    INIT_WIDTH        = 640,
  parameter int                    INIT_HEIGHT       = 132,
  parameter int                    INIT_H_BLANK      = 16,
  parameter int                    INIT_V_BLANK      = 2,
  parameter int                    INIT_BLOB_LEFT    = 0,
  parameter int                    INIT_BLOB_RIGHT   = 0,
  parameter int                    INIT_BLOB_TOP     = 0,
  parameter int                    INIT_BLOB_BOTTOM  = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_FG           = '1,
  parameter logic [DATA_WIDTH-1:0] INIT_BG           = '0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cke,
  input  logic                   enable,
  output logic                   busy,
  input  logic                   ctl_update,
  output logic [INDEX_WIDTH-1:0] ctl_index,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  input  logic [X_WIDTH-1:0]     param_h_blank,
  input  logic [Y_WIDTH-1:0]     param_v_blank,
  input  logic [X_WIDTH-1:0]     param_blob_left,
  input  logic [X_WIDTH-1:0]     param_blob_right,
  input  logic [Y_WIDTH-1:0]     param_blob_top,
  input  logic [Y_WIDTH-1:0]     param_blob_bottom,
  input  logic [DATA_WIDTH-1:0]  param_fg,
  input  logic [DATA_WIDTH-1:0]  param_bg,
  output logic                   m_img_line_first,
  output logic                   m_img_line_last,
  output logic                   m_img_pixel_first,
  output logic                   m_img_pixel_last,
  output logic                   m_img_de,
  output logic [DATA_WIDTH-1:0]  m_img_data,
  output logic                   m_img_valid
);

  logic [X_WIDTH-1:0]    reg_width, reg_h_blank, reg_left, reg_right;
  logic [Y_WIDTH-1:0]    reg_height, reg_v_blank, reg_top, reg_bottom;
  logic [DATA_WIDTH-1:0] reg_fg, reg_bg, bg_pix;

  logic               frame_start, active, de;
  logic               pixel_first, pixel_last, line_first, line_last;
  logic [X_WIDTH-1:0] x;
  logic [Y_WIDTH-1:0] y;
  logic               in_blob;

  jelly_img_blob_pattern_timing #(
    .X_WIDTH (X_WIDTH),
    .Y_WIDTH (Y_WIDTH)
  ) u_timing (
    .clk         (clk),
    .reset_n     (reset_n),
    .cke         (cke),
    .enable      (enable),
    .width       (reg_width),
    .height      (reg_height),
    .h_blank     (reg_h_blank),
    .v_blank     (reg_v_blank),
    .frame_start (frame_start),
    .busy        (busy),
    .active      (active),
    .de          (de),
    .pixel_first (pixel_first),
    .pixel_last  (pixel_last),
    .line_first  (line_first),
    .line_last   (line_last),
    .x           (x),
    .y           (y)
  );

  // frame_start already includes cke, so params never move mid-frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reg_width   <= X_WIDTH'(INIT_WIDTH);
      reg_height  <= Y_WIDTH'(INIT_HEIGHT);
      reg_h_blank <= X_WIDTH'(INIT_H_BLANK);
      reg_v_blank <= Y_WIDTH'(INIT_V_BLANK);
      reg_left    <= X_WIDTH'(INIT_BLOB_LEFT);
      reg_right   <= X_WIDTH'(INIT_BLOB_RIGHT);
      reg_top     <= Y_WIDTH'(INIT_BLOB_TOP);
      reg_bottom  <= Y_WIDTH'(INIT_BLOB_BOTTOM);
      reg_fg      <= INIT_FG;
      reg_bg      <= INIT_BG;
      ctl_index   <= '0;
    end else if (frame_start && ctl_update) begin
      reg_width   <= param_width;
      reg_height  <= param_height;
      reg_h_blank <= param_h_blank;
      reg_v_blank <= param_v_blank;
      reg_left    <= param_blob_left;
      reg_right   <= param_blob_right;
      reg_top     <= param_blob_top;
      reg_bottom  <= param_blob_bottom;
      reg_fg      <= param_fg;
      reg_bg      <= param_bg;
      ctl_index   <= ctl_index + INDEX_WIDTH'(1);
    end
  end

  // an inverted range yields an empty blob; de gating hides off-image hits
  assign in_blob = (x >= reg_left) && (x <= reg_right) && (y >= reg_top) && (y <= reg_bottom);

`ifdef JELLY_IMG_BLOB_PATTERN_GEN_NOISE_EN
  logic [15:0] lfsr;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       lfsr <= LFSR_SEED;
    else if (cke && de) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
  end
  assign bg_pix = reg_bg ^ DATA_WIDTH'(lfsr[1:0]);
`else
  assign bg_pix = reg_bg;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_img_valid       <= 1'b0;
      m_img_line_first  <= 1'b0;
      m_img_line_last   <= 1'b0;
      m_img_pixel_first <= 1'b0;
      m_img_pixel_last  <= 1'b0;
      m_img_de          <= 1'b0;
      m_img_data        <= '0;
    end else if (cke) begin
      m_img_valid       <= active;
      m_img_line_first  <= line_first;
      m_img_line_last   <= line_last;
      m_img_pixel_first <= pixel_first;
      m_img_pixel_last  <= pixel_last;
      m_img_de          <= de;
      m_img_data        <= de ? (in_blob ? reg_fg : bg_pix) : '0;
    end
  end

endmodule

// File: tb/tb_jelly_img_blob_pattern_gen.sv
module tb_jelly_img_blob_pattern_gen;
  localparam int XW = 14, YW = 14, DW = 8, IW = 1;

  logic          clk = 1'b0, reset_n = 1'b0, cke = 1'b1, enable = 1'b0, ctl_update = 1'b0;
  logic          busy;
  logic [IW-1:0] ctl_index;
  logic [XW-1:0] p_width, p_h_blank, p_left, p_right;
  logic [YW-1:0] p_height, p_v_blank, p_top, p_bottom;
  logic [DW-1:0] p_fg, p_bg;
  logic          lf, ll, pf, pl, de, valid;
  logic [DW-1:0] data;

  jelly_img_blob_pattern_gen #(.INDEX_WIDTH(IW), .DATA_WIDTH(DW), .X_WIDTH(XW), .Y_WIDTH(YW)) dut (
    .clk(clk), .reset_n(reset_n), .cke(cke), .enable(enable), .busy(busy),
    .ctl_update(ctl_update), .ctl_index(ctl_index),
    .param_width(p_width), .param_height(p_height), .param_h_blank(p_h_blank), .param_v_blank(p_v_blank),
    .param_blob_left(p_left), .param_blob_right(p_right), .param_blob_top(p_top), .param_blob_bottom(p_bottom),
    .param_fg(p_fg), .param_bg(p_bg),
    .m_img_line_first(lf), .m_img_line_last(ll), .m_img_pixel_first(pf), .m_img_pixel_last(pl),
    .m_img_de(de), .m_img_data(data), .m_img_valid(valid));

  always #5 clk = ~clk;

  typedef struct {logic v, lf, ll, pf, pl, de, bg; logic [DW-1:0] data;} beat_t;
  typedef struct {int w, h, hb, vb, l, r, t, b, fg, bg;} prm_t;

  beat_t         q[$];
  int            checks = 0, errors = 0, popped = 0, frames_seen = 0;
  bit            synced = 0, upd = 0, rnd_cke = 0;
  logic [IW-1:0] exp_idx = '0;
  logic [15:0]   lfsr_m = 16'hACE1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, got, want);
    end
  endtask

  // reference stream for one frame plus its v-blank, straight from the geometry rules
  task automatic push_frame(input prm_t p);
    int we, L;
    beat_t e;
    bit inb;
    we = (p.w == 0) ? 1 : p.w;
    L  = we + p.hb;
    for (int yy = 0; yy < p.h; yy++)
      for (int xx = 0; xx < L; xx++) begin
        inb    = (xx >= p.l) && (xx <= p.r) && (yy >= p.t) && (yy <= p.b);
        e.v    = 1'b1;
        e.lf   = (yy == 0);
        e.ll   = (yy == p.h - 1);
        e.pf   = (xx == 0);
        e.pl   = (xx == L - 1);
        e.de   = (xx < we);
        e.bg   = e.de && !inb;
        e.data = !e.de ? '0 : inb ? DW'(p.fg) : DW'(p.bg);
        q.push_back(e);
      end
    for (int i = 0; i < p.vb * L; i++) begin
      e = '{v: 1'b0, lf: 1'b0, ll: 1'b0, pf: 1'b0, pl: 1'b0, de: 1'b0, bg: 1'b0, data: '0};
      q.push_back(e);
    end
  endtask

  task automatic drive(input prm_t p);
    p_width = XW'(p.w); p_height = YW'(p.h); p_h_blank = XW'(p.hb); p_v_blank = YW'(p.vb);
    p_left = XW'(p.l); p_right = XW'(p.r); p_top = YW'(p.t); p_bottom = YW'(p.b);
    p_fg = DW'(p.fg); p_bg = DW'(p.bg);
  endtask

  always @(negedge clk) cke = rnd_cke ? 1'($urandom % 2) : 1'b1;
  always @(posedge clk) upd = cke && reset_n;

  // monitor: one pop per updated output cycle once the stream has started
  always @(negedge clk) begin
    if (!reset_n) begin
      synced = 0;
      lfsr_m = 16'hACE1;
    end else if (upd) begin
      if (q.size() == 0) begin
        synced = 0;
        if (valid) chk("idle_valid", 64'(valid), 64'd0);
      end else if (synced || valid) begin
        beat_t e;
        e = q.pop_front();
        synced = 1;
        popped++;
        if (e.de) begin
`ifdef JELLY_IMG_BLOB_PATTERN_GEN_NOISE_EN
          if (e.bg) e.data = e.data ^ DW'(lfsr_m[1:0]);
`endif
          lfsr_m = lfsr_m[0] ? ((lfsr_m >> 1) ^ 16'hB400) : (lfsr_m >> 1);
        end
        chk("beat", 64'({valid, lf, ll, pf, pl, de, data}),
                    64'({e.v, e.lf, e.ll, e.pf, e.pl, e.de, e.data}));
        if (valid && lf && pf) frames_seen++;
      end
    end
  end

  task automatic wait_idx(input logic [IW-1:0] v);
    for (int n = 0; n < 4000 && ctl_index !== v; n++) @(negedge clk);
    chk("ctl_index", 64'(ctl_index), 64'(v));
  endtask

  task automatic wait_frames(input int n);
    for (int i = 0; i < 8000 && frames_seen < n; i++) @(negedge clk);
    if (frames_seen < n) chk("frame_timeout", 64'(frames_seen), 64'(n));
  endtask

  task automatic wait_popped(input int n);
    for (int i = 0; i < 8000 && popped < n; i++) @(negedge clk);
    if (popped < n) chk("beat_timeout", 64'(popped), 64'(n));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 8000 && busy; i++) @(negedge clk);
    chk("busy_end", 64'(busy), 64'd0);
    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
  endtask

  // frame 1 uses p0 (applied from idle), a mid-frame update makes frames 2..n use p1
  task automatic run_phase(input prm_t p0, input prm_t p1, input int n, input bit rc);
    int f0;
    f0 = frames_seen;
    rnd_cke = rc;
    drive(p0);
    ctl_update = 1'b1;
    enable = 1'b1;
    push_frame(p0);
    for (int i = 1; i < n; i++) push_frame(p1);
    exp_idx = exp_idx + 1'b1;
    wait_idx(exp_idx);
    ctl_update = 1'b0;
    wait_frames(f0 + 1);
    drive(p1);
    ctl_update = 1'b1;
    chk("index_held_midframe", 64'(ctl_index), 64'(exp_idx));
    exp_idx = exp_idx + 1'b1;
    wait_idx(exp_idx);
    ctl_update = 1'b0;
    wait_frames(f0 + n);
    enable = 1'b0;
    wait_idle();
    rnd_cke = 0;
  endtask

  function automatic prm_t rnd_prm();
    prm_t p;
    p.w = $urandom_range(2, 8); p.h = $urandom_range(2, 4);
    p.hb = $urandom_range(0, 3); p.vb = $urandom_range(0, 2);
    p.l = $urandom_range(0, 9); p.r = $urandom_range(0, 9);
    p.t = $urandom_range(0, 4); p.b = $urandom_range(0, 4);
    p.fg = $urandom_range(0, 255); p.bg = $urandom_range(0, 255);
    return p;
  endfunction

  initial begin
    prm_t pa, pb, pz;
    pa = '{w: 8, h: 4, hb: 2, vb: 1, l: 2, r: 3, t: 1, b: 2, fg: 200, bg: 0};
    pb = pa; pb.w = 4;
    pz = '{w: 0, h: 3, hb: 2, vb: 0, l: 0, r: 0, t: 5, b: 1, fg: 9, bg: 77};
    drive(pa);
    repeat (3) @(negedge clk);
    chk("reset_state", 64'({valid, lf, ll, pf, pl, de, data, busy, ctl_index}), 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    run_phase(pa, pa, 2, 0);   // directed frame + blob
    run_phase(pa, pb, 3, 0);   // width change applied only at next frame
    run_phase(pa, pa, 2, 1);   // same stream under a random clock enable
    run_phase(pz, pa, 2, 0);   // zero width, inverted blob rows, v_blank=0 boundary
    for (int k = 0; k < 4; k++) run_phase(rnd_prm(), rnd_prm(), $urandom_range(2, 3), k[0]);

    // reset mid-frame after beat (5,1) has been presented
    drive(pa);
    ctl_update = 1'b1;
    enable = 1'b1;
    push_frame(pa);
    exp_idx = exp_idx + 1'b1;
    wait_idx(exp_idx);
    ctl_update = 1'b0;
    wait_popped(popped + 16);
    #2 reset_n = 1'b0;
    #1 chk("async_reset", 64'({valid, lf, ll, pf, pl, de, data, busy, ctl_index}), 64'd0);
    q.delete();
    exp_idx = '0;
    enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    run_phase(pa, pa, 2, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

endmodule
